// File: rtl/fifo_wr_arbiter_if.sv
// rtl/fifo_wr_arbiter_if.sv - requester/FIFO-side bundle for the FIFO write arbiter.
interface fifo_wr_arbiter_if #(
  parameter int WIDTH = 16,
  parameter int NREQ  = 4
);
  logic [NREQ-1:0]       req_i;
  logic [NREQ*WIDTH-1:0] wdata_i;
  logic [NREQ-1:0]       gnt_o;
  logic                  fifo_full_i;
  logic                  fifo_afull_i;
  logic                  fifo_wr_en_o;
  logic [WIDTH-1:0]      fifo_wdata_o;
  logic                  busy_o;

  modport master (
    input  req_i, wdata_i, fifo_full_i, fifo_afull_i,
    output gnt_o, fifo_wr_en_o, fifo_wdata_o, busy_o
  );

  modport slave (
    output req_i, wdata_i, fifo_full_i, fifo_afull_i,
    input  gnt_o, fifo_wr_en_o, fifo_wdata_o, busy_o
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin write arbiter feeding one FIFO, latency-1 write port.
// Define WR_ARB_BURST_EN to compile in burst grants of up to MAX_BURST words per requester.
module fifo_wr_arbiter #(
  parameter int WIDTH     = 16,
  parameter int NREQ      = 4,
  parameter int MAX_BURST = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  fifo_wr_arbiter_if.master     bus
);
  localparam int IDXW = $clog2(NREQ);

  typedef enum logic {IDLE, BURST} state_t;

  state_t           state;
  logic [IDXW-1:0]  last_gnt;
  logic [IDXW:0]    rr;
  logic             window;
  logic             gnt_vld;
  logic [IDXW-1:0]  gnt_idx;
  logic [WIDTH-1:0] sel_word;

`ifdef WR_ARB_BURST_EN
  localparam int CNTW = $clog2(MAX_BURST + 1);
  logic [IDXW-1:0]  burst_idx;
  logic [CNTW-1:0]  burst_cnt;
  logic             burst_hold;
`endif

  // {found, index} of the first requester after 'last', wrapping modulo NREQ.
  function automatic logic [IDXW:0] rr_pick(input logic [NREQ-1:0] req,
                                            input logic [IDXW-1:0] last);
    logic [IDXW:0] res;
    int            c;
    res = '0;
    for (int i = NREQ; i >= 1; i--) begin
      c = int'(last) + i;
      if (c >= NREQ) c = c - NREQ;
      if (req[IDXW'(c)]) res = {1'b1, IDXW'(c)};
    end
    return res;
  endfunction

  // A write in flight into the last free entry closes the window for a cycle.
  assign window = !bus.fifo_full_i && !(bus.fifo_wr_en_o && bus.fifo_afull_i);
  assign rr     = rr_pick(bus.req_i, last_gnt);
  assign bus.busy_o = (state == BURST);

`ifdef WR_ARB_BURST_EN
  assign burst_hold = (state == BURST) && bus.req_i[burst_idx] &&
                      (burst_cnt < CNTW'(MAX_BURST));
`endif

  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = rr[IDXW-1:0];
    if (rst_n_i && window) begin
`ifdef WR_ARB_BURST_EN
      if (burst_hold) begin
        gnt_vld = 1'b1;
        gnt_idx = burst_idx;
      end else begin
        gnt_vld = rr[IDXW];
      end
`else
      gnt_vld = rr[IDXW];
`endif
    end
    bus.gnt_o = gnt_vld ? (NREQ'(1) << gnt_idx) : '0;
  end

  always_comb begin
    sel_word = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (gnt_idx == IDXW'(k)) sel_word = bus.wdata_i[k*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      bus.fifo_wr_en_o <= 1'b0;
      bus.fifo_wdata_o <= '0;
      last_gnt         <= IDXW'(NREQ - 1);
      state            <= IDLE;
`ifdef WR_ARB_BURST_EN
      burst_idx        <= '0;
      burst_cnt        <= '0;
`endif
    end else begin
      bus.fifo_wr_en_o <= gnt_vld;
      if (gnt_vld) begin
        bus.fifo_wdata_o <= sel_word;
        last_gnt         <= gnt_idx;
      end
`ifdef WR_ARB_BURST_EN
      // A grant outside the current burst starts a new one; closed-window cycles freeze everything.
      if (gnt_vld) begin
        if (burst_hold) begin
          burst_cnt <= burst_cnt + 1'b1;
        end else begin
          state     <= BURST;
          burst_idx <= gnt_idx;
          burst_cnt <= CNTW'(1);
        end
      end else if (window) begin
        state     <= IDLE;
        burst_cnt <= '0;
      end
`endif
    end
  end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - directed self-checking bench for fifo_wr_arbiter.
module tb_fifo_wr_arbiter;
`ifdef WR_ARB_BURST_EN
  localparam bit BURST_BUILD = 1'b1;
`else
  localparam bit BURST_BUILD = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;

  fifo_wr_arbiter_if #(.WIDTH(16), .NREQ(4)) bus ();

  fifo_wr_arbiter #(.WIDTH(16), .NREQ(4), .MAX_BURST(4)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [15:0] word(input int k, input int c);
    return 16'((k + 1) * 4096 + c);
  endfunction

  task automatic drive(input logic rst, input logic [3:0] req, input logic full,
                       input logic afull, input int c);
    @(negedge clk);
    rst_n            = rst;
    bus.req_i        = req;
    bus.fifo_full_i  = full;
    bus.fifo_afull_i = afull;
    for (int k = 0; k < 4; k++) bus.wdata_i[k*16 +: 16] = word(k, c);
    #1;
  endtask

  task automatic clock_in();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int c = 0; c < 2; c++) begin
      drive(1'b0, 4'hF, 1'b0, 1'b0, c);
      n_cmp++; if (bus.gnt_o !== 4'b0000) begin n_bad++; $display("FAIL reset_gnt got %b want 0000", bus.gnt_o); end
      clock_in();
      n_cmp++; if (bus.fifo_wr_en_o !== 1'b0) begin n_bad++; $display("FAIL reset_wr_en got %b want 0", bus.fifo_wr_en_o); end
      n_cmp++; if (bus.fifo_wdata_o !== 16'h0000) begin n_bad++; $display("FAIL reset_wdata got %h want 0000", bus.fifo_wdata_o); end
      n_cmp++; if (bus.busy_o !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", bus.busy_o); end
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] eg;
    int         k;
    for (int c = 0; c < 5; c++) begin
      k  = c % 4;
      eg = 4'(1 << k);
      drive(1'b1, 4'hF, 1'b0, 1'b0, c);
      n_cmp++; if (bus.gnt_o !== eg) begin n_bad++; $display("FAIL rr_gnt c=%0d got %b want %b", c, bus.gnt_o, eg); end
      clock_in();
      n_cmp++; if (bus.fifo_wr_en_o !== 1'b1) begin n_bad++; $display("FAIL rr_wr_en c=%0d got %b want 1", c, bus.fifo_wr_en_o); end
      n_cmp++; if (bus.fifo_wdata_o !== word(k, c)) begin n_bad++; $display("FAIL rr_wdata c=%0d got %h want %h", c, bus.fifo_wdata_o, word(k, c)); end
      n_cmp++; if (bus.busy_o !== 1'b0) begin n_bad++; $display("FAIL rr_busy c=%0d got %b want 0", c, bus.busy_o); end
    end
  endtask

  task automatic test_wrap();
    logic [3:0] eg [3];
    int         ek [3];
    eg = '{4'b1000, 4'b0001, 4'b1000};
    ek = '{3, 0, 3};
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, 4'b1001, 1'b0, 1'b0, 10 + c);
      n_cmp++; if (bus.gnt_o !== eg[c]) begin n_bad++; $display("FAIL wrap_gnt c=%0d got %b want %b", c, bus.gnt_o, eg[c]); end
      clock_in();
      n_cmp++; if (bus.fifo_wr_en_o !== 1'b1) begin n_bad++; $display("FAIL wrap_wr_en c=%0d got %b want 1", c, bus.fifo_wr_en_o); end
      n_cmp++; if (bus.fifo_wdata_o !== word(ek[c], 10 + c)) begin n_bad++; $display("FAIL wrap_wdata c=%0d got %h want %h", c, bus.fifo_wdata_o, word(ek[c], 10 + c)); end
    end
  endtask

  task automatic test_burst();
    int         ek [11];
    logic [3:0] rq [11];
    ek = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 1};
    rq = '{4'b0011, 4'b0011, 4'b0011, 4'b0011, 4'b0011, 4'b0011,
           4'b0011, 4'b0011, 4'b0011, 4'b0001, 4'b0010};
    for (int c = 0; c < 11; c++) begin
      drive(1'b1, rq[c], 1'b0, 1'b0, 20 + c);
      n_cmp++; if (bus.gnt_o !== 4'(1 << ek[c])) begin n_bad++; $display("FAIL burst_gnt c=%0d got %b want %b", c, bus.gnt_o, 4'(1 << ek[c])); end
      clock_in();
      n_cmp++; if (bus.fifo_wr_en_o !== 1'b1) begin n_bad++; $display("FAIL burst_wr_en c=%0d got %b want 1", c, bus.fifo_wr_en_o); end
      n_cmp++; if (bus.fifo_wdata_o !== word(ek[c], 20 + c)) begin n_bad++; $display("FAIL burst_wdata c=%0d got %h want %h", c, bus.fifo_wdata_o, word(ek[c], 20 + c)); end
      n_cmp++; if (bus.busy_o !== 1'b1) begin n_bad++; $display("FAIL burst_busy c=%0d got %b want 1", c, bus.busy_o); end
    end
  endtask

  task automatic test_full();
    bit full_t [6];
    int last_c;
    full_t = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    last_c = 0;
    for (int c = 0; c < 6; c++) begin
      drive(1'b1, 4'b0100, full_t[c], 1'b0, 40 + c);
      n_cmp++; if (bus.gnt_o !== (full_t[c] ? 4'b0000 : 4'b0100)) begin n_bad++; $display("FAIL full_gnt c=%0d got %b want %b", c, bus.gnt_o, full_t[c] ? 4'b0000 : 4'b0100); end
      if (!full_t[c]) last_c = 40 + c;
      clock_in();
      n_cmp++; if (bus.fifo_wr_en_o !== !full_t[c]) begin n_bad++; $display("FAIL full_wr_en c=%0d got %b want %b", c, bus.fifo_wr_en_o, !full_t[c]); end
      n_cmp++; if (bus.fifo_wdata_o !== word(2, last_c)) begin n_bad++; $display("FAIL full_wdata c=%0d got %h want %h", c, bus.fifo_wdata_o, word(2, last_c)); end
    end
  endtask

  task automatic test_afull();
    logic [3:0] rq [4];
    bit         fl [4];
    bit         af [4];
    logic [3:0] eg [4];
    bit         ew [4];
    rq = '{4'b0000, 4'b0010, 4'b0010, 4'b0010};
    fl = '{1'b0, 1'b0, 1'b0, 1'b1};
    af = '{1'b0, 1'b1, 1'b1, 1'b0};
    eg = '{4'b0000, 4'b0010, 4'b0000, 4'b0000};
    ew = '{1'b0, 1'b1, 1'b0, 1'b0};
    for (int c = 0; c < 4; c++) begin
      drive(1'b1, rq[c], fl[c], af[c], 50 + c);
      n_cmp++; if (bus.gnt_o !== eg[c]) begin n_bad++; $display("FAIL afull_gnt c=%0d got %b want %b", c, bus.gnt_o, eg[c]); end
      clock_in();
      n_cmp++; if (bus.fifo_wr_en_o !== ew[c]) begin n_bad++; $display("FAIL afull_wr_en c=%0d got %b want %b", c, bus.fifo_wr_en_o, ew[c]); end
      if (c >= 1) begin
        n_cmp++; if (bus.fifo_wdata_o !== word(1, 51)) begin n_bad++; $display("FAIL afull_wdata c=%0d got %h want %h", c, bus.fifo_wdata_o, word(1, 51)); end
      end
    end
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 4'b0011, 1'b0, 1'b0, 60);
    clock_in();
    drive(1'b0, 4'b0011, 1'b0, 1'b0, 61);
    n_cmp++; if (bus.gnt_o !== 4'b0000) begin n_bad++; $display("FAIL rmid_gnt got %b want 0000", bus.gnt_o); end
    clock_in();
    n_cmp++; if (bus.fifo_wr_en_o !== 1'b0) begin n_bad++; $display("FAIL rmid_wr_en got %b want 0", bus.fifo_wr_en_o); end
    n_cmp++; if (bus.fifo_wdata_o !== 16'h0000) begin n_bad++; $display("FAIL rmid_wdata got %h want 0000", bus.fifo_wdata_o); end
    n_cmp++; if (bus.busy_o !== 1'b0) begin n_bad++; $display("FAIL rmid_busy got %b want 0", bus.busy_o); end
    drive(1'b1, 4'b0011, 1'b0, 1'b0, 62);
    n_cmp++; if (bus.gnt_o !== 4'b0001) begin n_bad++; $display("FAIL rmid_restart_gnt got %b want 0001", bus.gnt_o); end
    clock_in();
    n_cmp++; if (bus.fifo_wr_en_o !== 1'b1) begin n_bad++; $display("FAIL rmid_restart_wr_en got %b want 1", bus.fifo_wr_en_o); end
    n_cmp++; if (bus.fifo_wdata_o !== word(0, 62)) begin n_bad++; $display("FAIL rmid_restart_wdata got %h want %h", bus.fifo_wdata_o, word(0, 62)); end
    n_cmp++; if (bus.busy_o !== BURST_BUILD) begin n_bad++; $display("FAIL rmid_restart_busy got %b want %b", bus.busy_o, BURST_BUILD); end
  endtask

  initial begin
    n_cmp            = 0;
    n_bad            = 0;
    rst_n            = 1'b0;
    bus.req_i        = '0;
    bus.wdata_i      = '0;
    bus.fifo_full_i  = 1'b0;
    bus.fifo_afull_i = 1'b0;
    test_reset();
`ifdef WR_ARB_BURST_EN
    test_burst();
`else
    test_round_robin();
    test_wrap();
`endif
    test_full();
    test_afull();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
